riscv_timer_irq: RTL and testbench

- Memory-mapped machine-timer and interrupt source, downstream of the RISC-V VProc wrapper's data master port.
- Consumes daddress/dwrite/dwritedata/dbyteenable/dread accesses routed to it by interconnect decode (cs), and returns dreaddata/dwaitrequest.
- Drives the wrapper's irq[2:0]: software, timer and synchronised external interrupt.

---
 rtl/riscv_timer_irq.sv | 222 ++++++++++++++++++++++
 tb/tb_riscv_timer_irq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_timer_irq.sv
// -----------------------------------------------------------------------------
// riscv_timer_irq
//
// Memory-mapped machine timer and interrupt source sitting on the VProc
// wrapper's data master port. Provides a prescaled 64-bit mtime counter, a
// 64-bit mtimecmp compare register, a software interrupt bit (msip) and a
// synchronised external interrupt, and drives the wrapper's irq[2:0].
//
// Ports:
//   clk          system clock
//   nreset       asynchronous active-low reset
//   cs           slave select from the interconnect address decode
//   address      byte offset; [4:2] selects the register, [1:0] ignored
//   write        write strobe (zero wait states)
//   writedata    write data
//   byteenable   byte lanes for writes
//   read         read strobe (one wait state)
//   readdata     read data, valid when read && !waitrequest
//   waitrequest  stall to the master, only raised on the first read cycle
//   ext_irq_in   asynchronous external interrupt request
//   irq          [0]=msip, [1]=timer, [2]=external (synchronised)
//
// Register map (word index = address[4:2]):
//   0 mtime_lo   1 mtime_hi (reads the shadow captured by mtime_lo reads)
//   2 mtimecmp_lo  3 mtimecmp_hi  4 msip (bit0)  5 status (RO)  6,7 read 0
// -----------------------------------------------------------------------------
module riscv_timer_irq #(
  parameter int unsigned CLK_DIV      = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        cs,
  input  logic [4:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        waitrequest,
  input  logic        ext_irq_in,
  output logic [2:0]  irq
);

  localparam logic [15:0] DIV_TC = 16'(CLK_DIV - 1);

  localparam logic [2:0] REG_MTIME_LO    = 3'd0;
  localparam logic [2:0] REG_MTIME_HI    = 3'd1;
  localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] REG_MSIP        = 3'd4;
  localparam logic [2:0] REG_STATUS      = 3'd5;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rdState_t;

  rdState_t    r_rdState;
  rdState_t    w_rdNext;

  logic [15:0] r_prescale;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_msip;
  logic        r_irqTimer;
  logic        r_sync1;
  logic        r_sync2;
  logic [31:0] r_hiShadow;
  logic [31:0] r_readdata;

  logic [2:0]  w_regSel;
  logic        w_wr;
  logic        w_rdReq;
  logic        w_rdStart;
  logic        w_tick;
  logic [31:0] w_rdMux;
  logic        w_unusedAddr;

  // Sub-word byte offset carries no meaning for word-wide registers.
  assign w_unusedAddr = ^address[1:0];

  assign w_regSel = address[4:2];
  assign w_wr     = cs && write;
  // A simultaneous read and write is handled purely as a write.
  assign w_rdReq  = cs && read && !write;
  assign w_tick   = (r_prescale == DIV_TC);

  // Merge the enabled byte lanes of new data into an old register word.
  function automatic logic [31:0] mergeLanes(input logic [31:0] oldVal,
                                             input logic [31:0] newVal,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? newVal[8*i +: 8] : oldVal[8*i +: 8];
    end
    return res;
  endfunction

  // Prescaler: counts 0..CLK_DIV-1 and wraps, tick at terminal count.
  // Bus writes to mtime never disturb its phase.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_prescale <= '0;
    end else if (w_tick) begin
      r_prescale <= '0;
    end else begin
      r_prescale <= r_prescale + 16'd1;
    end
  end

  // mtime: a write to either half suppresses the increment for that cycle
  // so software sees exactly the value it wrote.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_mtime <= '0;
    end else if (w_wr && (w_regSel == REG_MTIME_LO)) begin
      r_mtime[31:0] <= mergeLanes(r_mtime[31:0], writedata, byteenable);
    end else if (w_wr && (w_regSel == REG_MTIME_HI)) begin
      r_mtime[63:32] <= mergeLanes(r_mtime[63:32], writedata, byteenable);
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  // mtimecmp and msip registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_mtimecmp <= MTIMECMP_RST;
      r_msip     <= 1'b0;
    end else if (w_wr) begin
      case (w_regSel)
        REG_MTIMECMP_LO: r_mtimecmp[31:0]  <= mergeLanes(r_mtimecmp[31:0], writedata, byteenable);
        REG_MTIMECMP_HI: r_mtimecmp[63:32] <= mergeLanes(r_mtimecmp[63:32], writedata, byteenable);
        REG_MSIP: begin
          if (byteenable[0]) begin
            r_msip <= writedata[0];
          end
        end
        default: ;
      endcase
    end
  end

  // Timer interrupt compares the current register values, so it lags any
  // change of mtime or mtimecmp by one cycle. The external request passes
  // through a two-flop synchroniser and stays level-sensitive.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_irqTimer <= 1'b0;
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
    end else begin
      r_irqTimer <= (r_mtime >= r_mtimecmp);
      r_sync1    <= ext_irq_in;
      r_sync2    <= r_sync1;
    end
  end

  // Read data selection. mtime_hi returns the shadow so a lo-then-hi read
  // pair always sees one coherent 64-bit snapshot.
  always_comb begin
    w_rdMux = '0;
    case (w_regSel)
      REG_MTIME_LO:    w_rdMux = r_mtime[31:0];
      REG_MTIME_HI:    w_rdMux = r_hiShadow;
      REG_MTIMECMP_LO: w_rdMux = r_mtimecmp[31:0];
      REG_MTIMECMP_HI: w_rdMux = r_mtimecmp[63:32];
      REG_MSIP:        w_rdMux = {31'd0, r_msip};
      REG_STATUS:      w_rdMux = {30'd0, r_sync2, r_irqTimer};
      default:         w_rdMux = '0;
    endcase
  end

  // Read phase state register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_rdState <= RD_IDLE;
    end else begin
      r_rdState <= w_rdNext;
    end
  end

  // Read phase next state: the first read cycle stalls the master while the
  // data is registered; the following cycle presents it with no stall.
  // waitrequest is gated by reset so it drops the moment reset asserts.
  always_comb begin
    w_rdNext    = RD_IDLE;
    w_rdStart   = 1'b0;
    waitrequest = 1'b0;
    case (r_rdState)
      RD_IDLE: begin
        if (w_rdReq) begin
          w_rdStart   = 1'b1;
          waitrequest = nreset;
          w_rdNext    = RD_DATA;
        end
      end
      RD_DATA: begin
        w_rdNext = RD_IDLE;
      end
      default: w_rdNext = RD_IDLE;
    endcase
  end

  // Read data and hi shadow capture. readdata holds between reads.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_readdata <= '0;
      r_hiShadow <= '0;
    end else if (w_rdStart) begin
      r_readdata <= w_rdMux;
      if (w_regSel == REG_MTIME_LO) begin
        r_hiShadow <= r_mtime[63:32];
      end
    end
  end

  assign readdata = r_readdata;
  assign irq      = {r_sync2, r_irqTimer, r_msip};

endmodule

// File: tb/tb_riscv_timer_irq.sv
// -----------------------------------------------------------------------------
// tb_riscv_timer_irq
//
// Directed bench for riscv_timer_irq. Two instances run side by side: one with
// CLK_DIV=1 and one with CLK_DIV=4, each with its own select and reset.
// Read expectations are queued when a read is issued; a monitor pops and
// compares them whenever a read completes (read && !waitrequest).
// -----------------------------------------------------------------------------
module tb_riscv_timer_irq;

  localparam logic [4:0] A_MTIME_LO    = 5'h00;
  localparam logic [4:0] A_MTIME_HI    = 5'h04;
  localparam logic [4:0] A_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] A_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] A_MSIP        = 5'h10;
  localparam logic [4:0] A_REG6        = 5'h18;

  logic        clk;
  logic        nreset1;
  logic        nreset4;
  logic        cs1;
  logic        cs4;
  logic [4:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        read;
  logic        extIrq;
  logic [31:0] readdata1;
  logic [31:0] readdata4;
  logic        wait1;
  logic        wait4;
  logic [2:0]  irq1;
  logic [2:0]  irq4;

  int          vectors;
  int          miscompares;
  logic [31:0] expQ1[$];
  logic [31:0] expQ4[$];

  riscv_timer_irq #(.CLK_DIV(1)) u_div1 (
    .clk         (clk),
    .nreset      (nreset1),
    .cs          (cs1),
    .address     (address),
    .write       (write),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .read        (read),
    .readdata    (readdata1),
    .waitrequest (wait1),
    .ext_irq_in  (extIrq),
    .irq         (irq1)
  );

  riscv_timer_irq #(.CLK_DIV(4)) u_div4 (
    .clk         (clk),
    .nreset      (nreset4),
    .cs          (cs4),
    .address     (address),
    .write       (write),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .read        (read),
    .readdata    (readdata4),
    .waitrequest (wait4),
    .ext_irq_in  (extIrq),
    .irq         (irq4)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value against its hand-computed expectation.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Read monitor: compares completing reads with the queued expectations.
  always @(negedge clk) begin
    if (cs1 && read && !write && !wait1) begin
      if (expQ1.size() == 0) begin
        checkOutput("div1_unexpected_read", {32'd0, readdata1}, 64'hDEAD_BEEF_0000_0000);
      end else begin
        checkOutput("div1_readdata", {32'd0, readdata1}, {32'd0, expQ1.pop_front()});
      end
    end
    if (cs4 && read && !write && !wait4) begin
      if (expQ4.size() == 0) begin
        checkOutput("div4_unexpected_read", {32'd0, readdata4}, 64'hDEAD_BEEF_0000_0000);
      end else begin
        checkOutput("div4_readdata", {32'd0, readdata4}, {32'd0, expQ4.pop_front()});
      end
    end
  end

  // Advance n clock edges, ending 1 unit after the last rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Single-cycle write to the selected instance.
  task automatic doWrite(input int sel, input logic [4:0] addr,
                         input logic [31:0] data, input logic [3:0] be);
    address    = addr;
    writedata  = data;
    byteenable = be;
    write      = 1'b1;
    read       = 1'b0;
    cs1        = (sel == 1);
    cs4        = (sel == 4);
    #2;
    checkOutput("wr_nowait", (sel == 1) ? wait1 : wait4, 1'b0);
    @(posedge clk);
    #1;
    cs1   = 1'b0;
    cs4   = 1'b0;
    write = 1'b0;
  endtask

  // Two-cycle read: expectation queued, stall checked on the first cycle.
  task automatic doRead(input int sel, input logic [4:0] addr, input logic [31:0] expected);
    if (sel == 1) expQ1.push_back(expected);
    else          expQ4.push_back(expected);
    address = addr;
    write   = 1'b0;
    read    = 1'b1;
    cs1     = (sel == 1);
    cs4     = (sel == 4);
    #2;
    checkOutput("rd_wait_first", (sel == 1) ? wait1 : wait4, 1'b1);
    tick(2);
    cs1  = 1'b0;
    cs4  = 1'b0;
    read = 1'b0;
  endtask

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  task automatic applyStimulus;
    // Reset state, including a read attempted while in reset.
    tick(2);
    checkOutput("rst_irq1", irq1, 3'b000);
    checkOutput("rst_irq4", irq4, 3'b000);
    checkOutput("rst_readdata1", readdata1, 32'd0);
    checkOutput("rst_wait1", wait1, 1'b0);
    address = A_MTIME_LO;
    cs1     = 1'b1;
    read    = 1'b1;
    #2;
    checkOutput("rst_wait_during_reset", wait1, 1'b0);
    cs1  = 1'b0;
    read = 1'b0;
    tick(1);
    nreset1 = 1'b1;
    nreset4 = 1'b1;

    // Five increments after release, then sample mtime_lo.
    tick(5);
    checkOutput("irq1_idle", irq1, 3'b000);
    doRead(1, A_MTIME_LO, 32'd5);

    // Carry across halves and shadow behaviour.
    doWrite(1, A_MTIME_LO, 32'hFFFF_FFFE, 4'hF);
    doWrite(1, A_MTIME_HI, 32'h0, 4'hF);
    tick(3);
    doRead(1, A_MTIME_LO, 32'd1);
    doRead(1, A_MTIME_HI, 32'd1);
    doWrite(1, A_MTIME_HI, 32'h55, 4'hF);
    doRead(1, A_MTIME_HI, 32'd1);

    // Timer compare at mtimecmp = 100.
    doWrite(1, A_MTIMECMP_HI, 32'd0, 4'hF);
    doWrite(1, A_MTIMECMP_LO, 32'd100, 4'hF);
    doWrite(1, A_MTIME_HI, 32'd0, 4'hF);
    doWrite(1, A_MTIME_LO, 32'd0, 4'hF);
    tick(1);
    checkOutput("timer_low_after_clear", irq1[1], 1'b0);
    tick(98);
    checkOutput("timer_low_at_99", irq1[1], 1'b0);
    tick(1);
    checkOutput("timer_low_when_reaching_100", irq1[1], 1'b0);
    tick(1);
    checkOutput("timer_high_one_after_100", irq1[1], 1'b1);
    doWrite(1, A_MTIMECMP_LO, 32'd1000, 4'hF);
    checkOutput("timer_still_high_on_write", irq1[1], 1'b1);
    tick(1);
    checkOutput("timer_falls_after_raise", irq1[1], 1'b0);

    // Software interrupt, reserved register, ignored sub-word offset.
    doWrite(1, A_MSIP, 32'd1, 4'hF);
    checkOutput("msip_set", irq1[0], 1'b1);
    doRead(1, 5'h13, 32'd1);
    doWrite(1, A_MSIP, 32'd0, 4'hF);
    checkOutput("msip_clear", irq1[0], 1'b0);
    doWrite(1, A_REG6, 32'hFFFF_FFFF, 4'hF);
    doRead(1, A_REG6, 32'd0);

    // External interrupt: 5-cycle pulse, seen 2 edges later for 5 cycles.
    extIrq = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (k == 5) extIrq = 1'b0;
      checkOutput($sformatf("ext_irq_k%0d", k), irq1[2], (k >= 2 && k <= 6) ? 1'b1 : 1'b0);
    end

    // Reset asserted in the middle of a read on the CLK_DIV=4 instance.
    address = A_MTIME_LO;
    read    = 1'b1;
    cs4     = 1'b1;
    #2;
    checkOutput("div4_wait_before_reset", wait4, 1'b1);
    nreset4 = 1'b0;
    #1;
    checkOutput("div4_wait_drops_in_reset", wait4, 1'b0);
    cs4  = 1'b0;
    read = 1'b0;
    tick(2);
    nreset4 = 1'b1;
    checkOutput("div4_readdata_reset", readdata4, 32'd0);

    // Write mtime_lo on the tick cycle (fourth edge after release).
    tick(3);
    doWrite(4, A_MTIME_LO, 32'd10, 4'hF);
    doRead(4, A_MTIME_LO, 32'd10);
    tick(2);
    doRead(4, A_MTIME_LO, 32'd11);

    // Byte-enable write onto the reset value of mtimecmp.
    doWrite(4, A_MTIMECMP_LO, 32'hA5A5_A5A5, 4'b0010);
    doRead(4, A_MTIMECMP_LO, 32'hFFFF_A5FF);
    doRead(4, A_MTIMECMP_HI, 32'hFFFF_FFFF);

    // Read/write collision: write only, no stall.
    address    = A_MSIP;
    writedata  = 32'd1;
    byteenable = 4'hF;
    cs4        = 1'b1;
    read       = 1'b1;
    write      = 1'b1;
    #2;
    checkOutput("collision_nowait", wait4, 1'b0);
    tick(1);
    cs4   = 1'b0;
    read  = 1'b0;
    write = 1'b0;
    checkOutput("collision_wrote_msip", irq4[0], 1'b1);
    doRead(4, A_MSIP, 32'd1);

    tick(2);
    checkOutput("div1_queue_drained", expQ1.size(), 0);
    checkOutput("div4_queue_drained", expQ4.size(), 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    nreset1     = 1'b0;
    nreset4     = 1'b0;
    cs1         = 1'b0;
    cs4         = 1'b0;
    address     = '0;
    write       = 1'b0;
    writedata   = '0;
    byteenable  = '0;
    read        = 1'b0;
    extIrq      = 1'b0;
    applyStimulus();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
